// File: rtl/elelock_multi.sv
// Parametrised keypad lock: DIGITS-digit secret entered on a one-hot 10-key pad,
// explicit enter, consecutive-failure counting and a timed lockout with alarm.
// All outputs are registered and change at the clock edge that detects the event.
module elelock_multi #(
    parameter int                  DIGITS      = 4,
    parameter logic [4*DIGITS-1:0] SECRET      = 16'h1234,
    parameter int                  MAX_FAIL    = 3,
    parameter int                  LOCKOUT_CYC = 1000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [9:0]                      tenkey,
    input  logic                            enter,
    input  logic                            close,
    output logic                            lock,
    output logic                            alarm,
    output logic [$clog2(DIGITS+1)-1:0]     digit_cnt,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

    localparam int DC_W = $clog2(DIGITS + 1);
    localparam int FC_W = $clog2(MAX_FAIL + 1);
    localparam int TM_W = $clog2(LOCKOUT_CYC + 1);
    localparam int BW   = 4 * DIGITS;

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_LOCKOUT  = 2'd2
    } state_t;

    state_t            state_q,     state_d;
    logic              lock_q,      lock_d;
    logic              alarm_q,     alarm_d;
    logic [BW-1:0]     buf_q,       buf_d;
    logic [DC_W-1:0]   digit_cnt_q, digit_cnt_d;
    logic [FC_W-1:0]   fail_cnt_q,  fail_cnt_d;
    logic [TM_W-1:0]   timer_q,     timer_d;
    logic [9:0]        tenkey_q,    tenkey_d;
    logic              enter_q,     enter_d;

    logic              key_onehot;
    logic              key_accept;
    logic [3:0]        key_idx;
    logic              enter_pulse;
    logic              code_ok;

    // Key qualification: a fresh press is exactly one-hot after an idle (all-zero) sample.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, otherwise a latch is inferred.
        key_idx    = 4'd0;
        key_onehot = (tenkey != 10'd0) && ((tenkey & (tenkey - 10'd1)) == 10'd0);
        for (int k = 0; k < 10; k++) begin
            if (tenkey[k]) key_idx = 4'(k);
        end
        key_accept  = key_onehot && (tenkey_q == 10'd0);
        enter_pulse = enter && !enter_q;
        code_ok     = (digit_cnt_q == DC_W'(DIGITS)) && (buf_q == SECRET);
    end

    // Next-state and next-output logic for the lock controller.
    always_comb begin
        state_d     = state_q;
        lock_d      = lock_q;
        alarm_d     = alarm_q;
        buf_d       = buf_q;
        digit_cnt_d = digit_cnt_q;
        fail_cnt_d  = fail_cnt_q;
        timer_d     = timer_q;
        tenkey_d    = tenkey;
        enter_d     = enter;

        case (state_q)
            ST_LOCKED: begin
                if (close) begin
                    // Abort the entry; a coincident enter is swallowed.
                    buf_d       = '1;
                    digit_cnt_d = '0;
                end else if (enter_pulse) begin
                    // Enter judges the buffer as it stands; a same-cycle key is dropped.
                    if (code_ok) begin
                        state_d    = ST_UNLOCKED;
                        lock_d     = 1'b0;
                        fail_cnt_d = '0;
                    end else begin
                        buf_d       = '1;
                        digit_cnt_d = '0;
                        fail_cnt_d  = fail_cnt_q + 1'b1;
                        if (fail_cnt_q == FC_W'(MAX_FAIL - 1)) begin
                            state_d = ST_LOCKOUT;
                            alarm_d = 1'b1;
                            timer_d = TM_W'(LOCKOUT_CYC);
                        end
                    end
                end else if (key_accept) begin
                    // Newest digit enters nibble 0; older digits move up.
                    buf_d      = buf_q << 4;
                    buf_d[3:0] = key_idx;
                    if (digit_cnt_q != DC_W'(DIGITS)) digit_cnt_d = digit_cnt_q + 1'b1;
                end
            end
            ST_UNLOCKED: begin
                if (close) begin
                    state_d     = ST_LOCKED;
                    lock_d      = 1'b1;
                    buf_d       = '1;
                    digit_cnt_d = '0;
                end
            end
            ST_LOCKOUT: begin
                // Timer was loaded with LOCKOUT_CYC on entry; leaving on the edge
                // where it reads 1 keeps alarm high for exactly LOCKOUT_CYC cycles.
                if (timer_q == TM_W'(1)) begin
                    state_d     = ST_LOCKED;
                    alarm_d     = 1'b0;
                    fail_cnt_d  = '0;
                    buf_d       = '1;
                    digit_cnt_d = '0;
                    timer_d     = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d     = ST_LOCKED;
                lock_d      = 1'b1;
                alarm_d     = 1'b0;
                buf_d       = '1;
                digit_cnt_d = '0;
                fail_cnt_d  = '0;
                timer_d     = '0;
            end
        endcase
    end

    // State and output registers; reset forces the safe locked state at once.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the digit buffer is a handful of flops, not a RAM, so it is reset like any other state.
        if (!rst_n) begin
            state_q     <= ST_LOCKED;
            lock_q      <= 1'b1;
            alarm_q     <= 1'b0;
            buf_q       <= '1;
            digit_cnt_q <= '0;
            fail_cnt_q  <= '0;
            timer_q     <= '0;
            tenkey_q    <= 10'd0;
            enter_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            lock_q      <= lock_d;
            alarm_q     <= alarm_d;
            buf_q       <= buf_d;
            digit_cnt_q <= digit_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
            timer_q     <= timer_d;
            tenkey_q    <= tenkey_d;
            enter_q     <= enter_d;
        end
    end

    assign lock      = lock_q;
    assign alarm     = alarm_q;
    assign digit_cnt = digit_cnt_q;
    assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_elelock_multi.sv
// Bench for elelock_multi: a digit-queue model of the lock rules is compared to
// the DUT after every clock edge, and directed scenarios add literal checks.
module tb_elelock_multi;

    localparam int DIGITS      = 4;
    localparam int MAX_FAIL    = 3;
    localparam int LOCKOUT_CYC = 1000;
    localparam int DC_W        = $clog2(DIGITS + 1);
    localparam int FC_W        = $clog2(MAX_FAIL + 1);

    logic            clk    = 1'b0;
    logic            rst_n  = 1'b0;
    logic [9:0]      tenkey = 10'd0;
    logic            enter  = 1'b0;
    logic            close  = 1'b0;
    logic            lock;
    logic            alarm;
    logic [DC_W-1:0] digit_cnt;
    logic [FC_W-1:0] fail_cnt;

    int checks   = 0;
    int failures = 0;

    elelock_multi #(
        .DIGITS     (DIGITS),
        .SECRET     (16'h1234),
        .MAX_FAIL   (MAX_FAIL),
        .LOCKOUT_CYC(LOCKOUT_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tenkey   (tenkey),
        .enter    (enter),
        .close    (close),
        .lock     (lock),
        .alarm    (alarm),
        .digit_cnt(digit_cnt),
        .fail_cnt (fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Secret as the digit sequence the user types, first to last.
    int         secret_digits[DIGITS] = '{1, 2, 3, 4};
    int         m_digits[$];        // most recent digits typed, oldest first
    bit         m_open;
    int         m_lockout_left;     // cycles of lockout still to run
    int         m_fails;
    logic [9:0] m_prev_key;
    logic       m_prev_enter;

    function automatic bit code_matches();
        if (m_digits.size() != DIGITS) return 1'b0;
        for (int j = 0; j < DIGITS; j++)
            if (m_digits[j] != secret_digits[j]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        bit key_edge;
        bit enter_edge;
        int idx;
        if (!rst_n) begin
            m_digits.delete();
            m_open = 0; m_lockout_left = 0; m_fails = 0;
            m_prev_key = 10'd0; m_prev_enter = 1'b0;
            return;
        end
        key_edge   = ($countones(tenkey) == 1) && (m_prev_key == 10'd0);
        enter_edge = enter && !m_prev_enter;
        idx = 0;
        for (int k = 0; k < 10; k++) if (tenkey[k]) idx = k;
        if (m_lockout_left > 0) begin
            m_lockout_left--;
            if (m_lockout_left == 0) begin
                m_fails = 0;
                m_digits.delete();
            end
        end else if (m_open) begin
            if (close) begin
                m_open = 0;
                m_digits.delete();
            end
        end else begin
            if (close) begin
                m_digits.delete();
            end else if (enter_edge) begin
                if (code_matches()) begin
                    m_open  = 1;
                    m_fails = 0;
                end else begin
                    m_fails++;
                    m_digits.delete();
                    if (m_fails == MAX_FAIL) m_lockout_left = LOCKOUT_CYC;
                end
            end else if (key_edge) begin
                m_digits.push_back(idx);
                if (m_digits.size() > DIGITS) void'(m_digits.pop_front());
            end
        end
        m_prev_key   = tenkey;
        m_prev_enter = enter;
    endtask

    // Compare process: advance the model on each edge, check DUT just after it.
    always @(posedge clk) begin
        model_step();
        #1;
        check("cyc_lock",      32'(lock),      32'(!m_open));
        check("cyc_alarm",     32'(alarm),     32'(m_lockout_left > 0));
        check("cyc_digit_cnt", 32'(digit_cnt), 32'(m_digits.size()));
        check("cyc_fail_cnt",  32'(fail_cnt),  32'(m_fails));
    end

    // ---------------- stimulus helpers (all driven at negedge) ----------------
    task automatic press(input int k);
        tenkey = 10'd1 << k;
        @(negedge clk);
        tenkey = 10'd0;
        @(negedge clk);
    endtask

    task automatic pulse_enter();
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_close();
        close = 1'b1;
        @(negedge clk);
        close = 1'b0;
        @(negedge clk);
    endtask

    task automatic type_secret();
        press(1); press(2); press(3); press(4);
    endtask

    // Third wrong enter leaves alarm visible at the following negedge.
    task automatic three_wrong_enters();
        pulse_enter();
        pulse_enter();
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "simulation did not finish");
    end

    initial begin : stim
        int alarm_cycles;

        // Reset values while rst_n is held low.
        @(negedge clk);
        check("rst_lock",      32'(lock),      32'd1);
        check("rst_alarm",     32'(alarm),     32'd0);
        check("rst_digit_cnt", 32'(digit_cnt), 32'd0);
        check("rst_fail_cnt",  32'(fail_cnt),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: correct code opens the lock.
        type_secret();
        check("t1_digits", 32'(digit_cnt), 32'd4);
        check("t1_locked_before", 32'(lock), 32'd1);
        pulse_enter();
        check("t1_open", 32'(lock), 32'd0);
        check("t1_fail", 32'(fail_cnt), 32'd0);

        // 5: keys ignored while open, close relocks, code reopens.
        press(5);
        check("t5_key_ignored", 32'(digit_cnt), 32'd4);
        pulse_close();
        check("t5_relock", 32'(lock), 32'd1);
        check("t5_cleared", 32'(digit_cnt), 32'd0);
        type_secret();
        pulse_enter();
        check("t5_reopen", 32'(lock), 32'd0);
        pulse_close();

        // 6: key 4 coincident with enter is discarded, entry is short.
        press(1); press(2); press(3);
        tenkey = 10'd1 << 4;
        enter  = 1'b1;
        @(negedge clk);
        tenkey = 10'd0;
        enter  = 1'b0;
        @(negedge clk);
        check("t6_fail", 32'(fail_cnt), 32'd1);
        check("t6_lock", 32'(lock), 32'd1);
        check("t6_digits", 32'(digit_cnt), 32'd0);

        // Extra leading digit: count saturates, last four digits decide.
        press(9); type_secret();
        check("sat_digits", 32'(digit_cnt), 32'd4);
        pulse_enter();
        check("sat_open", 32'(lock), 32'd0);
        check("sat_fail_clr", 32'(fail_cnt), 32'd0);
        pulse_close();

        // Close together with enter while locked: no failure counted.
        press(1); press(2);
        close = 1'b1;
        enter = 1'b1;
        @(negedge clk);
        close = 1'b0;
        enter = 1'b0;
        @(negedge clk);
        check("close_enter_fail", 32'(fail_cnt), 32'd0);
        check("close_enter_digits", 32'(digit_cnt), 32'd0);

        // 2: short entry counts as a failure.
        press(1); press(2); press(3);
        pulse_enter();
        check("t2_lock", 32'(lock), 32'd1);
        check("t2_fail", 32'(fail_cnt), 32'd1);
        check("t2_digits", 32'(digit_cnt), 32'd0);

        // 3: held key counts once; multi-hot pattern ignored.
        tenkey = 10'd1 << 3;
        repeat (5) @(negedge clk);
        tenkey = 10'b0000011000;
        repeat (2) @(negedge clk);
        tenkey = 10'd0;
        @(negedge clk);
        check("t3_digits", 32'(digit_cnt), 32'd1);
        pulse_close();
        check("t3_close_keeps_fail", 32'(fail_cnt), 32'd1);
        type_secret();
        pulse_enter();
        pulse_close();

        // 4: three wrong enters, lockout of exactly LOCKOUT_CYC cycles.
        three_wrong_enters();
        check("t4_alarm_on", 32'(alarm), 32'd1);
        check("t4_fail_max", 32'(fail_cnt), 32'd3);
        alarm_cycles = alarm ? 1 : 0;
        for (int i = 0; i < LOCKOUT_CYC + 100 && alarm; i++) begin
            tenkey = (i % 7 == 0) ? (10'd1 << (i % 10)) : 10'd0;
            enter  = (i % 5 == 0);
            close  = (i % 11 == 0);
            @(negedge clk);
            if (alarm) alarm_cycles++;
            if (alarm && lock !== 1'b1) check("t4_lock_held", 32'(lock), 32'd1);
        end
        tenkey = 10'd0;
        enter  = 1'b0;
        close  = 1'b0;
        check("t4_alarm_cycles", 32'(alarm_cycles), 32'(LOCKOUT_CYC));
        check("t4_exit_alarm", 32'(alarm), 32'd0);
        check("t4_exit_fail", 32'(fail_cnt), 32'd0);
        check("t4_exit_lock", 32'(lock), 32'd1);
        check("t4_exit_digits", 32'(digit_cnt), 32'd0);
        @(negedge clk);
        type_secret();
        pulse_enter();
        check("t4_after_open", 32'(lock), 32'd0);
        pulse_close();

        // Asynchronous reset in the middle of a lockout.
        three_wrong_enters();
        repeat (100) @(negedge clk);
        check("ar_in_lockout", 32'(alarm), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_alarm", 32'(alarm), 32'd0);
        check("ar_lock", 32'(lock), 32'd1);
        check("ar_fail", 32'(fail_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        type_secret();
        pulse_enter();
        check("ar_open_after", 32'(lock), 32'd0);
        pulse_close();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
